elevator_scan_scheduler: RTL
============================

Name: elevator_scan_scheduler

Overview:
- Parametrised successor to the 3-floor priority queue. Latches hall/car requests for N_FLOORS floors and schedules them with a SCAN (elevator) policy: keep moving in the current direction while requests remain ahead, then reverse.
- Owns the current-floor register, the per-floor travel timer and the door-open timer.
- Sits between the request/LED front-end and the motor and door drivers in systems/moviment.

Parameters:
- N_FLOORS, 3: number of floors, 2..16.
- FLOOR_W, 2: floor index width; must satisfy 2^FLOOR_W >= N_FLOORS.
- TRAVEL_CYCLES, 4: clock cycles to move one floor; minimum 1.
- DOOR_CYCLES, 8: clock cycles the door stays open; minimum 1.
- HOME_FLOOR, 0: park floor, used only with the optional feature.
- IDLE_CYCLES, 16: idle timeout before parking, used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_FLOORS  request per floor; bit i is sampled on every clk edge, and a 1 sets pending[i].
- pending  out  N_FLOORS  latched outstanding requests (drives the floor LEDs).
- cur_floor  out  FLOOR_W  floor the car is at, or last passed.
- target_floor  out  FLOOR_W  next scheduled stop; equals cur_floor when there is no next stop.
- moving  out  1  high in state MOVE.
- dir_up  out  1  travel direction; 1 = up. Holds its value while idle.
- door_open  out  1  high in state DOOR.
- arrive  out  1  one-cycle pulse on the edge where a stop is made.

Behaviour:
- Reset values: state IDLE, pending=0, cur_floor=0, target_floor=0, dir_up=1, moving=0, door_open=0, arrive=0, all counters 0.
- Reset asserted mid-MOVE or mid-DOOR aborts the operation immediately. No request survives reset.
- Request latching: pending[i] <= pending[i] | req[i], except bits cleared in the same edge by service. A request at the floor being served is never latched.
- Definitions: above = any pending bit with index > cur_floor; below = any pending bit with index < cur_floor.
- IDLE, evaluated on registered pending, in priority order:
  - pending[cur_floor] set: go to DOOR, clear the bit, pulse arrive.
  - Else above and (dir_up or !below): go to MOVE, dir_up=1.
  - Else below: go to MOVE, dir_up=0.
  - Else stay in IDLE.
- MOVE:
  - The travel counter counts 0..TRAVEL_CYCLES-1.
  - On the terminal edge, cur_floor steps ±1 and the counter resets.
  - If the new floor has pending set, or req set for it on that same edge: go to DOOR, clear the bit, pulse arrive.
  - Otherwise continue in MOVE.
  - A request entered behind the car waits for the reversal.
  - cur_floor never leaves 0..N_FLOORS-1. An empty direction at the boundary forces DOOR/IDLE; there is no wrap-around.
- DOOR:
  - door_open=1 for DOOR_CYCLES cycles, then go to IDLE.
  - req for cur_floor during DOOR reloads the door timer to 0 and is not latched.
- target_floor is combinational from state:
  - MOVE: nearest pending floor in dir_up.
  - IDLE: the floor the next MOVE would head toward.
  - Otherwise: cur_floor.
- Latency: a request sampled on edge E0 while IDLE at another floor enters MOVE on E1. It arrives on edge E1 + k*TRAVEL_CYCLES, where k is the floor distance.

Optional Feature:
- Macro: ELEVATOR_IDLE_HOME_EN.
- Defined: an idle counter increments each cycle in IDLE with pending==0 and cur_floor!=HOME_FLOOR.
  - On reaching IDLE_CYCLES, the car moves toward HOME_FLOOR as a park trip.
  - The park trip pulses arrive on arrival but does not open the door, and returns to IDLE.
  - Any latched request aborts the park trip at the next floor boundary, and normal SCAN resumes.
  - The idle counter clears on any non-IDLE state or any pending bit.
- Undefined: no idle counter; the car stays at its last floor indefinitely. HOME_FLOOR and IDLE_CYCLES have no effect.

Test Plan:
- Basic trip: defaults, idle at 0, pulse req[2] at edge 0 → moving on edge 1; cur_floor=1 at edge 5; cur_floor=2, arrive=1, door_open=1 at edge 9; pending=000; IDLE after 8 door cycles.
- Current-floor request: idle at floor 1, req[1] pulse → DOOR next edge, pending[1] never set, arrive pulses once.
- SCAN ordering: N_FLOORS=5, car at 2 moving up toward 4; req[0] and req[3] arrive mid-travel → stops at 3, then 4, then reverses to 0. dir_up goes 1→0 only after the floor-4 door closes.
- Door hold: in DOOR at floor 0, req[0] on cycle 5 → door_open stays high 8 more cycles; pending stays 0.
- Reset mid-move: assert rst while moving 1→2 with pending=100 → all outputs return to reset values asynchronously; after release, idle at floor 0 with no motion.
- ELEVATOR_IDLE_HOME_EN: idle at floor 2 with no requests → after 16 idle cycles, moves down and reaches floor 0 with arrive=1 and door_open=0. Repeat with the macro undefined → cur_floor stays 2.

Source files
------------

// File: rtl/elevator_scan_if.sv
// Request/status bundle between the request front-end (master) and the SCAN scheduler (slave).
interface elevator_scan_if #(
    parameter int N_FLOORS = 3,
    parameter int FLOOR_W  = 2
);
    logic [N_FLOORS-1:0] req;
    logic [N_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0]  cur_floor;
    logic [FLOOR_W-1:0]  target_floor;
    logic                moving;
    logic                dir_up;
    logic                door_open;
    logic                arrive;

    modport master (
        output req,
        input  pending, cur_floor, target_floor, moving, dir_up, door_open, arrive
    );

    modport slave (
        input  req,
        output pending, cur_floor, target_floor, moving, dir_up, door_open, arrive
    );
endinterface

// File: rtl/elevator_scan_scheduler.sv
// SCAN elevator scheduler: latches floor requests, owns floor register, travel and door timers.
// Optional park-at-home behaviour is enabled by defining ELEVATOR_IDLE_HOME_EN.
//
// state  | meaning
// S_IDLE | car stopped, door closed, choosing next direction
// S_MOVE | travelling between floors (normal trip or park trip)
// S_DOOR | stopped at cur_floor with the door open
module elevator_scan_scheduler #(
    parameter int N_FLOORS      = 3,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8,
    parameter int HOME_FLOOR    = 0,
    parameter int IDLE_CYCLES   = 16
) (
    input  logic           clk,
    input  logic           rst,
    elevator_scan_if.slave bus
);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    if (N_FLOORS < 2 || N_FLOORS > 16 || (1 << FLOOR_W) < N_FLOORS || TRAVEL_CYCLES < 1 ||
        DOOR_CYCLES < 1 || HOME_FLOOR < 0 || HOME_FLOOR >= N_FLOORS || IDLE_CYCLES < 1) begin : g_bad_cfg
        $error("elevator_scan_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t              state_q, state_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
    logic                dir_up_q, dir_up_d;
    logic                arrive_q, arrive_d;
    logic [TW-1:0]       travel_cnt_q, travel_cnt_d;
    logic [DW-1:0]       door_cnt_q, door_cnt_d;

`ifdef ELEVATOR_IDLE_HOME_EN
    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [IW-1:0]      IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] HOME      = FLOOR_W'(HOME_FLOOR);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          park_q, park_d;
`endif

    logic                above, below, ahead_next, at_bound;
    logic [FLOOR_W-1:0]  near_above, near_below, next_floor;
    logic [N_FLOORS-1:0] pend_all;

    always_comb begin
        above      = 1'b0;
        below      = 1'b0;
        near_above = cur_floor_q;
        near_below = cur_floor_q;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && FLOOR_W'(i) > cur_floor_q) begin
                above      = 1'b1;
                near_above = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending_q[i] && FLOOR_W'(i) < cur_floor_q) begin
                below      = 1'b1;
                near_below = FLOOR_W'(i);
            end
        end
        at_bound   = dir_up_q ? (cur_floor_q == TOP_FLOOR) : (cur_floor_q == '0);
        next_floor = at_bound ? cur_floor_q :
                     (dir_up_q ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1));
        // Requests arriving on the step edge count when deciding whether to stop or keep going.
        pend_all   = pending_q | bus.req;
        ahead_next = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pend_all[i] && (dir_up_q ? (FLOOR_W'(i) > next_floor) : (FLOOR_W'(i) < next_floor)))
                ahead_next = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | bus.req;
        cur_floor_d  = cur_floor_q;
        dir_up_d     = dir_up_q;
        arrive_d     = 1'b0;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
`ifdef ELEVATOR_IDLE_HOME_EN
        idle_cnt_d   = '0;
        park_d       = park_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                travel_cnt_d = '0;
                door_cnt_d   = '0;
                if (pending_q[cur_floor_q] || bus.req[cur_floor_q]) begin
                    state_d                = S_DOOR;
                    pending_d[cur_floor_q] = 1'b0;
                    arrive_d               = 1'b1;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = S_MOVE;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = S_MOVE;
                    dir_up_d = 1'b0;
                end else begin
`ifdef ELEVATOR_IDLE_HOME_EN
                    if (cur_floor_q != HOME) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d  = S_MOVE;
                            park_d   = 1'b1;
                            dir_up_d = (HOME > cur_floor_q);
                        end else begin
                            idle_cnt_d = idle_cnt_q + IW'(1);
                        end
                    end
`endif
                end
            end
            S_MOVE: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    travel_cnt_d = '0;
                    cur_floor_d  = next_floor;
                    if (pend_all[next_floor]) begin
                        state_d               = S_DOOR;
                        pending_d[next_floor] = 1'b0;
                        arrive_d              = 1'b1;
                        door_cnt_d            = '0;
`ifdef ELEVATOR_IDLE_HOME_EN
                        park_d                = 1'b0;
                    end else if (park_q) begin
                        // Park ends at home (no door) or is abandoned once real work is latched.
                        if (next_floor == HOME || pending_q != '0) begin
                            state_d  = S_IDLE;
                            park_d   = 1'b0;
                            arrive_d = (next_floor == HOME);
                        end
`endif
                    end else if (!ahead_next) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + TW'(1);
                end
            end
            S_DOOR: begin
                pending_d[cur_floor_q] = 1'b0;
                if (bus.req[cur_floor_q]) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = S_IDLE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.target_floor = cur_floor_q;
        if (state_q == S_MOVE) begin
            bus.target_floor = dir_up_q ? near_above : near_below;
`ifdef ELEVATOR_IDLE_HOME_EN
            if (park_q) bus.target_floor = HOME;
`endif
        end else if (state_q == S_IDLE && !pending_q[cur_floor_q]) begin
            if (above && (dir_up_q || !below)) bus.target_floor = near_above;
            else if (below)                    bus.target_floor = near_below;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            cur_floor_q  <= '0;
            dir_up_q     <= 1'b1;
            arrive_q     <= 1'b0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
`ifdef ELEVATOR_IDLE_HOME_EN
            idle_cnt_q   <= '0;
            park_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cur_floor_q  <= cur_floor_d;
            dir_up_q     <= dir_up_d;
            arrive_q     <= arrive_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
`ifdef ELEVATOR_IDLE_HOME_EN
            idle_cnt_q   <= idle_cnt_d;
            park_q       <= park_d;
`endif
        end
    end

    assign bus.pending   = pending_q;
    assign bus.cur_floor = cur_floor_q;
    assign bus.moving    = (state_q == S_MOVE);
    assign bus.dir_up    = dir_up_q;
    assign bus.door_open = (state_q == S_DOOR);
    assign bus.arrive    = arrive_q;
endmodule
